// File: rtl/ls_osc_pkg.sv
// rtl/ls_osc_pkg.sv - shared types and constants for the low-speed oscillator
package ls_osc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } ls_osc_state_t;

    localparam int LS_OSC_DEFAULT_HALF = 24;

endpackage

// File: rtl/ls_oscillator_if.sv
// rtl/ls_oscillator_if.sv - control and output bundle of the low-speed oscillator
interface ls_oscillator_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [CNT_W-1:0] div_half;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             tick_fall;
    logic             running;

    modport master (
        output en, div_half, div_load,
        input  clk_out, tick, tick_fall, running
    );

    modport slave (
        input  en, div_half, div_load,
        output clk_out, tick, tick_fall, running
    );
endinterface

// File: rtl/ls_oscillator.sv
// rtl/ls_oscillator.sv - programmable divider producing a slow square wave and edge strobes
module ls_oscillator
    import ls_osc_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = LS_OSC_DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             reset,
    ls_oscillator_if.slave   bus
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

    ls_osc_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_act_q;
    logic [CNT_W-1:0] half_pend_q;
    logic             clk_out_q;
    logic             tick_q;
    logic             tick_fall_q;

    logic [CNT_W-1:0] half_pend_d;
    logic             last_d;

    // A zero divisor would never terminate a phase, so it is clamped to one.
    assign half_pend_d = (bus.div_half == '0) ? ONE : bus.div_half;
    assign last_d      = (cnt_q == half_act_q - ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_act_q  <= DEF_HALF;
            half_pend_q <= DEF_HALF;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            tick_fall_q <= 1'b0;
        end else begin
            tick_q      <= 1'b0;
            tick_fall_q <= 1'b0;
            if (bus.div_load) begin
                half_pend_q <= half_pend_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_q    <= LOW;
                        cnt_q      <= '0;
                        half_act_q <= half_pend_q;
                    end
                end
                LOW: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (last_d) begin
                        state_q   <= HIGH;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b1;
                        tick_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                HIGH: begin
                    // The high phase always runs to completion so no runt pulse is emitted.
                    if (last_d) begin
                        clk_out_q   <= 1'b0;
                        tick_fall_q <= 1'b1;
                        cnt_q       <= '0;
                        if (bus.en) begin
                            state_q    <= LOW;
                            half_act_q <= half_pend_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.clk_out   = clk_out_q;
    assign bus.tick      = tick_q;
    assign bus.tick_fall = tick_fall_q;
    assign bus.running   = (state_q != IDLE);

endmodule

// File: tb/tb_ls_oscillator.sv
// tb/tb_ls_oscillator.sv - directed self-checking bench for ls_oscillator
module tb_ls_oscillator;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n;

    ls_oscillator_if #(.CNT_W(16)) bus ();

    ls_oscillator #(.CNT_W(16), .DEFAULT_HALF(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps until the chosen strobe is seen; n is the number of edges taken, -1 on timeout.
    task automatic wait_strobe(input bit want_fall, input int max, output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = -1;
        for (int i = 1; i <= max && !seen; i++) begin
            step();
            if ((want_fall ? bus.tick_fall : bus.tick) === 1'b1) begin
                seen = 1'b1;
                cnt  = i;
            end
        end
    endtask

    task automatic load(input logic [15:0] v);
        bus.div_half = v;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.div_half = '0;
        bus.div_load = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_clk_out", bus.clk_out, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_tick_fall", bus.tick_fall, 0);
        check("rst_running", bus.running, 0);

        // default half 24
        bus.en = 1'b1;
        step();
        check("en_running", bus.running, 1);
        check("en_clk_out_low", bus.clk_out, 0);
        wait_strobe(1'b0, 100, n);
        check("first_tick_24", n, 24);
        check("tick_clk_out_high", bus.clk_out, 1);
        check("tick_no_fall", bus.tick_fall, 0);

        // load 3 mid-HIGH: current period finishes at 24
        load(16'd3);
        wait_strobe(1'b1, 100, n);
        check("high_24_remaining", n, 23);
        check("fall_clk_out_low", bus.clk_out, 0);
        check("fall_no_tick", bus.tick, 0);
        wait_strobe(1'b0, 100, n);
        check("low_3", n, 3);
        wait_strobe(1'b1, 100, n);
        check("high_3", n, 3);
        wait_strobe(1'b0, 100, n);
        check("low_3_again", n, 3);

        // load 0 behaves as 1
        load(16'd0);
        wait_strobe(1'b1, 100, n);
        check("high_3_before_half1", n, 2);
        wait_strobe(1'b0, 100, n);
        check("half1_low", n, 1);
        wait_strobe(1'b1, 100, n);
        check("half1_high", n, 1);
        step();
        check("half1_toggle_hi", bus.clk_out, 1);
        check("half1_tick", bus.tick, 1);
        step();
        check("half1_toggle_lo", bus.clk_out, 0);
        check("half1_tick_fall", bus.tick_fall, 1);
        check("half1_no_tick", bus.tick, 0);

        // half 4, en dropped 2 cycles into HIGH
        load(16'd4);
        check("half1_tick_during_load", bus.tick, 1);
        step();
        check("half1_fall_before_4", bus.tick_fall, 1);
        wait_strobe(1'b0, 100, n);
        check("low_4", n, 4);
        step();
        step();
        bus.en = 1'b0;
        wait_strobe(1'b1, 100, n);
        check("high_completes_4", n, 2);
        check("drop_clk_out", bus.clk_out, 0);
        check("drop_running", bus.running, 0);
        step();
        check("drop_fall_one_cycle", bus.tick_fall, 0);
        check("drop_idle_running", bus.running, 0);

        // en dropped during LOW
        bus.en = 1'b1;
        step();
        check("low_drop_running_before", bus.running, 1);
        step();
        step();
        bus.en = 1'b0;
        step();
        check("low_drop_running", bus.running, 0);
        check("low_drop_no_tick", bus.tick, 0);
        wait_strobe(1'b0, 10, n);
        check("idle_no_tick", n, 32'hFFFF_FFFF);

        // reset mid-HIGH restores the default divisor
        load(16'd8);
        bus.en = 1'b1;
        step();
        wait_strobe(1'b0, 100, n);
        check("low_8", n, 8);
        step();
        step();
        reset = 1'b1;
        step();
        check("midrst_clk_out", bus.clk_out, 0);
        check("midrst_tick", bus.tick, 0);
        check("midrst_tick_fall", bus.tick_fall, 0);
        check("midrst_running", bus.running, 0);
        reset = 1'b0;
        step();
        check("post_rst_running", bus.running, 1);
        wait_strobe(1'b0, 100, n);
        check("post_rst_low_24", n, 24);
        wait_strobe(1'b1, 100, n);
        check("post_rst_high_24", n, 24);

        // load coinciding with period start is deferred one period
        bus.en = 1'b0;
        step();
        check("park_running", bus.running, 0);
        load(16'd5);
        bus.en       = 1'b1;
        bus.div_half = 16'd2;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        wait_strobe(1'b0, 100, n);
        check("coinc_low_5", n, 5);
        wait_strobe(1'b1, 100, n);
        check("coinc_high_5", n, 5);
        wait_strobe(1'b0, 100, n);
        check("next_low_2", n, 2);
        wait_strobe(1'b1, 100, n);
        check("next_high_2", n, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
